// File: rtl/spi_pwm_cfg_ctrl.sv
// spi_pwm_cfg_ctrl
// Write-only SPI (mode 0, MSB first) configuration port for the PWM/output
// datapath. The SPI pins are oversampled in the clk domain, 16-bit frames
// are assembled in a shift register, and valid writes load one of five
// 8-bit configuration registers.
//
// Handshake/pulse semantics: wr_strobe and frame_err are single-cycle,
// registered pulses. They are mutually exclusive and both coincide with
// the cycle in which a frame's outcome becomes visible on the register
// outputs. There is no backpressure; the SPI master owns pacing and must
// hold ncs high for at least SYNC_STAGES+3 clk between frames.
module spi_pwm_cfg_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);
    localparam logic [4:0] CNT_FULL   = 5'd16;
    localparam logic [4:0] CNT_SAT    = 5'd17;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic                   sclk_prev_q;
    logic                   ncs_prev_q;

    logic sclk_s;
    logic ncs_s;
    logic copi_s;
    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;

    // Shift raw pins through the synchronizer chains; all clear to 0 so a
    // high ncs at reset release only produces an ignored rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '0;
            copi_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
        end
    end

    // Remember the previous synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;

    // ------------------------------------------------------------------
    // Frame FSM, shift register and bit counter
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;

    // State, shift register and bit counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state logic: ncs_rise takes priority over a coincident sclk_rise,
    // so the final sclk edge of a frame closed in the same clk is dropped.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise) begin
                    shreg_d   = {shreg_q[14:0], copi_s};
                    // Saturate at 17: anything past 16 is simply "overrun".
                    bit_cnt_d = (bit_cnt_q >= CNT_SAT) ? CNT_SAT : bit_cnt_q + 5'd1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Frame decode (only meaningful in COMMIT)
    // ------------------------------------------------------------------
    logic       in_commit;
    logic       len_ok;
    logic       is_write;
    logic [6:0] addr;
    logic [7:0] data;
    logic       addr_ok;
    logic       do_write;
    logic       do_error;

    assign in_commit = (state_q == ST_COMMIT);
    assign len_ok    = (bit_cnt_q == CNT_FULL);
    assign is_write  = shreg_q[15];
    assign addr      = shreg_q[14:8];
    assign data      = shreg_q[7:0];
    assign addr_ok   = (addr <= MAX_ADDR_L);

    // Reads of correct length are dropped quietly; bad length or an
    // out-of-range write address is flagged.
    assign do_write = in_commit & len_ok & is_write & addr_ok;
    assign do_error = in_commit & ~(len_ok & (~is_write | addr_ok));

    // ------------------------------------------------------------------
    // Configuration registers and status pulses
    // ------------------------------------------------------------------
    logic [7:0] out_lo_q, out_lo_d;
    logic [7:0] out_hi_q, out_hi_d;
    logic [7:0] pwm_lo_q, pwm_lo_d;
    logic [7:0] pwm_hi_q, pwm_hi_d;
    logic [7:0] duty_q,   duty_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic       frame_err_q, frame_err_d;

    // Select the addressed register on a valid write; everything else holds.
    // Addresses above 4 but within MAX_ADDR have no backing register.
    always_comb begin
        out_lo_d    = out_lo_q;
        out_hi_d    = out_hi_q;
        pwm_lo_d    = pwm_lo_q;
        pwm_hi_d    = pwm_hi_q;
        duty_d      = duty_q;
        wr_strobe_d = do_write;
        frame_err_d = do_error;
        if (do_write) begin
            case (addr)
                7'h00:   out_lo_d = data;
                7'h01:   out_hi_d = data;
                7'h02:   pwm_lo_d = data;
                7'h03:   pwm_hi_d = data;
                7'h04:   duty_d   = data;
                default: ;
            endcase
        end
    end

    // Register bank and pulse flops; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo_q    <= '0;
            out_hi_q    <= '0;
            pwm_lo_q    <= '0;
            pwm_hi_q    <= '0;
            duty_q      <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            out_lo_q    <= out_lo_d;
            out_hi_q    <= out_hi_d;
            pwm_lo_q    <= pwm_lo_d;
            pwm_hi_q    <= pwm_hi_d;
            duty_q      <= duty_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign wr_strobe       = wr_strobe_q;
    assign frame_err       = frame_err_q;

endmodule
